// File: rtl/register_file.sv
// register_file -- 2**ADDR_W x DATA_W register file, two combinational read
// ports and one synchronous write port. Register 0 is hardwired to zero.
//
// Ports:
//   Clk                     rising-edge clock for all writes
//   Reset_n                 async active-low reset; clears every register
//   Read_Reg1 / Read_Reg2   read addresses
//   Read_Data1 / Read_Data2 read data (ALU operands A / B)
//   Write_Reg, Write_Data   write address / data
//   Reg_Write               write enable
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of the address being written in
//                      the same cycle returns Write_Data combinationally.
//                      When undefined, reads see array contents only (old
//                      value before the edge, new value after).

module register_file_cell #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  q <= '0;
    else if (we)   q <= d;
  end
endmodule

module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Read_Reg1,
  input  logic [ADDR_W-1:0] Read_Reg2,
  input  logic [ADDR_W-1:0] Write_Reg,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Reg_Write,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];

  // Register 0 has no storage; it is a constant zero on the read side.
  assign regs_q[0] = '0;

  generate
    for (genvar i = 1; i < NREG; i++) begin : g_reg
      register_file_cell #(.DATA_W(DATA_W)) u_cell (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .we      (Reg_Write && (Write_Reg == ADDR_W'(i))),
        .d       (Write_Data),
        .q       (regs_q[i])
      );
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = Reg_Write && (Write_Reg != '0);
`endif

  // The array is already zero during reset; the explicit gate also keeps the
  // bypass path from leaking Write_Data while Reset_n is low.
  always_comb begin
    Read_Data1 = regs_q[Read_Reg1];
    Read_Data2 = regs_q[Read_Reg2];
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (Write_Reg == Read_Reg1)) Read_Data1 = Write_Data;
    if (byp_ok && (Write_Reg == Read_Reg2)) Read_Data2 = Write_Data;
`endif
    if (!Reset_n) begin
      Read_Data1 = '0;
      Read_Data2 = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              Clk, Reset_n;
  logic [ADDR_W-1:0] Read_Reg1, Read_Reg2, Write_Reg;
  logic [DATA_W-1:0] Write_Data, Read_Data1, Read_Data2;
  logic              Reg_Write;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Read_Reg1  (Read_Reg1),
    .Read_Reg2  (Read_Reg2),
    .Write_Reg  (Write_Reg),
    .Write_Data (Write_Data),
    .Reg_Write  (Reg_Write),
    .Read_Data1 (Read_Data1),
    .Read_Data2 (Read_Data2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [NREG];
  logic        chk_vld;
  int          n_cmp, n_bad;

  // Reference: what a read port must show given the current model and the
  // inputs presented this cycle.
  function automatic logic [31:0] ref_rd(input int addr);
    if (!Reset_n) return 32'h0;
    if (addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (Reg_Write && int'(Write_Reg) == addr) return Write_Data;
`endif
    return model[addr];
  endfunction

  // Inputs applied just after a rising edge; expectations queued for the
  // monitor, which samples at the falling edge.
  task automatic cycle(input string name, input bit chk, input bit we,
                       input int wa, input logic [31:0] wd,
                       input int ra1, input int ra2);
    exp_t e;
    Reg_Write  = we;
    Write_Reg  = ADDR_W'(wa);
    Write_Data = wd;
    Read_Reg1  = ADDR_W'(ra1);
    Read_Reg2  = ADDR_W'(ra2);
    chk_vld    = chk;
    if (chk) begin
      e.name = name;
      e.e1   = ref_rd(ra1 % NREG);
      e.e2   = ref_rd(ra2 % NREG);
      sb_q.push_back(e);
    end
    @(posedge Clk); #1;
    if (we && Reset_n && (wa % NREG) != 0) model[wa % NREG] = wd;
  endtask

  always @(negedge Clk) begin
    if (chk_vld) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_underflow: monitor had no expectation");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        if (Read_Data1 !== e.e1) begin
          n_bad++;
          $display("FAIL %s rd1: got %h want %h", e.name, Read_Data1, e.e1);
        end
        n_cmp++;
        if (Read_Data2 !== e.e2) begin
          n_bad++;
          $display("FAIL %s rd2: got %h want %h", e.name, Read_Data2, e.e2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    n_cmp = 0; n_bad = 0; chk_vld = 0;
    Reset_n = 0; Reg_Write = 0; Write_Reg = '0; Write_Data = '0;
    Read_Reg1 = '0; Read_Reg2 = '0;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;

    @(posedge Clk); #1;
    // Reads during reset are zero; this write is discarded.
    cycle("reset_rd", 1, 1, 4, 32'h1111_2222, 4, 9);
    Reset_n = 1;
    cycle("post_reset_rd", 1, 0, 0, 0, 4, 9);

    // Basic write/read.
    cycle("wr1", 0, 1, 1, 32'h1069_6671, 0, 0);
    cycle("wr2", 0, 1, 2, 32'h1234_5678, 0, 0);
    cycle("basic_rd", 1, 0, 0, 0, 1, 2);

    // Register 0 is hardwired.
    cycle("wr0", 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
    cycle("reg0_rd", 1, 0, 0, 0, 0, 0);

    // Write disabled.
    cycle("wr_dis", 1, 0, 3, 32'hDEAD_BEEF, 3, 3);
    cycle("wr_dis_rd", 1, 0, 0, 0, 3, 3);

    // Same-cycle read/write of reg 5.
    cycle("wr5", 0, 1, 5, 32'h1, 0, 0);
    cycle("rw_same", 1, 1, 5, 32'h2, 5, 5);
    cycle("rw_after", 1, 0, 0, 0, 5, 5);

    // Back-to-back writes to one address and address wrap (37 -> 5).
    cycle("b2b_a", 0, 1, 6, 32'hAAAA_0001, 0, 0);
    cycle("b2b_b", 1, 1, 6, 32'hBBBB_0002, 6, 6);
    cycle("b2b_rd", 1, 1, 37, 32'h5A5A_5A5A, 6, 38);
    cycle("wrap_rd", 1, 0, 0, 0, 5, 37);

    // End-to-end with ALU add (ALU_Ctl=0010): operand A + operand B.
    cycle("alu_ops", 1, 0, 0, 0, 1, 2);
    a = 32'h1069_6671; b = 32'h1234_5678;
    cycle("alu_wr", 0, 1, 3, a + b, 0, 0);
    cycle("alu_rd", 1, 0, 0, 0, 3, 3);
    if (model[3] != 32'h229D_BCE9) begin
      n_cmp++; n_bad++;
      $display("FAIL alu_model: got %h want 229dbce9", model[3]);
    end

    // Asynchronous reset between edges with a write in flight.
    cycle("wr31", 0, 1, 31, 32'hCAFE_F00D, 0, 0);
    cycle("rd31", 1, 0, 0, 0, 31, 1);
    Reg_Write = 1; Write_Reg = 5'd31; Write_Data = 32'h0BAD_0BAD;
    Read_Reg1 = 5'd31; Read_Reg2 = 5'd2;
    #2 Reset_n = 0;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    begin
      exp_t e;
      e.name = "async_rst"; e.e1 = 32'h0; e.e2 = 32'h0;
      sb_q.push_back(e);
    end
    chk_vld = 1;
    @(posedge Clk); #1;
    cycle("rst_wr", 1, 1, 31, 32'h7777_7777, 31, 31);
    Reset_n = 1;
    cycle("rst_after", 1, 0, 0, 0, 31, 2);
    cycle("first_wr", 0, 1, 7, 32'h0707_0707, 0, 0);
    cycle("first_rd", 1, 0, 0, 0, 7, 31);

    // Randomized traffic; read addresses often collide with the write.
    for (int n = 0; n < 400; n++) begin
      int wa, r1, r2;
      wa = $urandom_range(0, NREG - 1);
      r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NREG - 1);
      r2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NREG - 1);
      cycle("rand", 1, $urandom_range(0, 1), wa, $urandom, r1, r2);
    end

    chk_vld = 0;
    repeat (2) @(posedge Clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
